// File: rtl/vproc_uart_tx.sv
// Byte FIFO plus 8N1 serializer for the vector processor console output.
// Define VPROC_UART_TX_PARITY_EN to append an even parity bit (8E1 framing).
module vproc_uart_tx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_we_i,
  input  logic [7:0] uart_data_i,
  input  logic       overflow_clr_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       fifo_full_o,
  output logic       overflow_o
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int PW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef VPROC_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  if (CPB < 2) begin : g_cpb_chk
    $error("vproc_uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("vproc_uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          full, empty, push, drop, pop;
  logic [7:0]    head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = uart_we_i && !full;
  // A write against a full FIFO is lost even if the FSM pops this cycle.
  assign drop  = uart_we_i && full;
  assign head  = mem[rd_ptr];
  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= uart_data_i;
  end

  // Serializer
  logic [2:0]    state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          baud_last, load, tx_n, busy_n;
`ifdef VPROC_UART_TX_PARITY_EN
  logic          par_q, par_n;
`endif

  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shift_n = shift;
    load    = 1'b0;
`ifdef VPROC_UART_TX_PARITY_EN
    par_n   = par_q;
`endif
    case (state)
      S_IDLE:  if (!empty) load = 1'b1;
      S_START: if (baud_last) begin
        state_n = S_DATA;
        bit_n   = 3'd0;
      end
      S_DATA:  if (baud_last) begin
        shift_n = {1'b0, shift[7:1]};
        bit_n   = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = S_AFTER_DATA;
      end
`ifdef VPROC_UART_TX_PARITY_EN
      S_PARITY: if (baud_last) state_n = S_STOP;
`endif
      S_STOP:  if (baud_last) begin
        if (!empty) load = 1'b1;
        else        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Popping from STOP skips IDLE so consecutive frames have no gap.
    if (load) begin
      state_n = S_START;
      shift_n = head;
`ifdef VPROC_UART_TX_PARITY_EN
      par_n   = ^head;
`endif
    end
    pop    = load;
    baud_n = (state == S_IDLE || baud_last) ? '0 : baud + BW'(1);
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
`ifdef VPROC_UART_TX_PARITY_EN
      S_PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != S_IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
      state      <= S_IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
`ifdef VPROC_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      if (drop)                overflow_o <= 1'b1;
      else if (overflow_clr_i) overflow_o <= 1'b0;
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx_o    <= tx_n;
      busy_o  <= busy_n;
`ifdef VPROC_UART_TX_PARITY_EN
      par_q   <= par_n;
`endif
    end
  end

  assign fifo_full_o = full;

endmodule

// File: tb/tb_vproc_uart_tx.sv
// Bench for vproc_uart_tx: queue-level line model checked every cycle plus
// hand-derived waveform points (CLKS_PER_BIT = 4, FIFO_DEPTH = 4).
module tb_vproc_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef VPROC_UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] data = 8'h00;
  logic       clr = 1'b0;
  logic       tx_o, busy_o, fifo_full_o, overflow_o;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  vproc_uart_tx #(.CLK_FREQ(100000000), .BAUD(25000000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_we_i(we), .uart_data_i(data),
    .overflow_clr_i(clr), .tx_o(tx_o), .busy_o(busy_o),
    .fifo_full_o(fifo_full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: byte queue plus a queue of per-cycle line levels for frames in flight.
  logic [7:0] mq[$];
  bit         wq[$];
  bit         m_ovf = 1'b0;
  bit         full_pre;
  logic [7:0] mb;
  logic       exp_tx = 1'b1, exp_busy = 1'b0, exp_full = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      wq.delete();
      m_ovf = 1'b0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      if (wq.size() != 0) void'(wq.pop_front());
      if (wq.size() == 0 && mq.size() != 0) begin
        mb = mq.pop_front();
        for (int c = 0; c < CPB; c++) wq.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int c = 0; c < CPB; c++) wq.push_back(mb[i]);
`ifdef VPROC_UART_TX_PARITY_EN
        for (int c = 0; c < CPB; c++) wq.push_back(^mb);
`endif
        for (int c = 0; c < CPB; c++) wq.push_back(1'b1);
      end
      if (we && !full_pre) mq.push_back(data);
      if (clr) m_ovf = 1'b0;
      if (we && full_pre) m_ovf = 1'b1;
    end
    exp_tx   = (wq.size() != 0) ? wq[0] : 1'b1;
    exp_busy = (wq.size() != 0) || (mq.size() != 0);
    exp_full = (mq.size() == DEPTH);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tx_o", {31'd0, tx_o}, {31'd0, exp_tx});
      chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
      chk("fifo_full_o", {31'd0, fifo_full_o}, {31'd0, exp_full});
      chk("overflow_o", {31'd0, overflow_o}, {31'd0, m_ovf});
    end
  end

  // Directed runs: trace index k is the cycle in which seq[k] is written.
  logic [7:0] seq [16];
  logic tx_tr [300], busy_tr [300], full_tr [300], ovf_tr [300];

  task automatic run(input int n, input int ncyc, input int clr_at);
    for (int k = 0; k <= ncyc; k++) begin
      @(negedge clk);
      tx_tr[k] = tx_o; busy_tr[k] = busy_o; full_tr[k] = fifo_full_o; ovf_tr[k] = overflow_o;
      we   = (k < n);
      data = (k < n) ? seq[k] : 8'h00;
      clr  = (k == clr_at);
    end
    we = 1'b0; clr = 1'b0;
  endtask

  logic [0:7] a5_bits;
  logic [7:0] dec;
  int         st, bad;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset tx_o", {31'd0, tx_o}, 32'd1);
    chk("reset busy_o", {31'd0, busy_o}, 32'd0);
    chk("reset fifo_full_o", {31'd0, fifo_full_o}, 32'd0);
    chk("reset overflow_o", {31'd0, overflow_o}, 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 single frame
    seq[0] = 8'hA5;
    run(1, 50, -1);
    a5_bits = 8'b10100101;
    chk("t1 idle before start", {31'd0, tx_tr[1]}, 32'd1);
    chk("t1 busy at 1", {31'd0, busy_tr[1]}, 32'd1);
    chk("t1 start c2", {31'd0, tx_tr[2]}, 32'd0);
    chk("t1 start c5", {31'd0, tx_tr[5]}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("t1 data bit first", {31'd0, tx_tr[6 + 4*i]}, {31'd0, a5_bits[i]});
      chk("t1 data bit last", {31'd0, tx_tr[9 + 4*i]}, {31'd0, a5_bits[i]});
    end
    chk("t1 stop first", {31'd0, tx_tr[2 + 4*(FL-1)]}, 32'd1);
    chk("t1 stop last", {31'd0, tx_tr[1 + 4*FL]}, 32'd1);
    chk("t1 busy last stop", {31'd0, busy_tr[1 + 4*FL]}, 32'd1);
    chk("t1 busy falls", {31'd0, busy_tr[2 + 4*FL]}, 32'd0);

    // 0x00 then 0xFF back to back
    seq[0] = 8'h00; seq[1] = 8'hFF;
    run(2, 2*4*FL + 8, -1);
    chk("t2 first data 0", {31'd0, tx_tr[6]}, 32'd0);
    chk("t2 first stop", {31'd0, tx_tr[1 + 4*FL]}, 32'd1);
    chk("t2 second start", {31'd0, tx_tr[2 + 4*FL]}, 32'd0);
    chk("t2 second data 1", {31'd0, tx_tr[6 + 4*FL]}, 32'd1);
    chk("t2 busy gapless", {31'd0, busy_tr[2 + 4*FL]}, 32'd1);
    chk("t2 busy falls", {31'd0, busy_tr[2 + 8*FL]}, 32'd0);

    // Overflow with depth 4
    for (int i = 0; i < 6; i++) seq[i] = 8'h10 + 8'(i);
    run(6, 5*4*FL + 10, -1);
    chk("t3 not full c4", {31'd0, full_tr[4]}, 32'd0);
    chk("t3 full c5", {31'd0, full_tr[5]}, 32'd1);
    chk("t3 ovf c5", {31'd0, ovf_tr[5]}, 32'd0);
    chk("t3 ovf c6", {31'd0, ovf_tr[6]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      st = 2 + i*4*FL;
      for (int j = 0; j < 8; j++) dec[j] = tx_tr[st + 6 + 4*j];
      chk("t3 decoded byte", {24'd0, dec}, 32'h10 + i);
    end
    chk("t3 no sixth frame", {31'd0, busy_tr[2 + 5*4*FL]}, 32'd0);

    // Clear, then clear coinciding with a drop
    run(0, 3, 1);
    chk("t4 ovf before clr", {31'd0, ovf_tr[1]}, 32'd1);
    chk("t4 ovf cleared", {31'd0, ovf_tr[2]}, 32'd0);
    for (int i = 0; i < 6; i++) seq[i] = 8'h20 + 8'(i);
    run(6, 5*4*FL + 10, 5);
    chk("t4 ovf pre-drop", {31'd0, ovf_tr[5]}, 32'd0);
    chk("t4 set beats clr", {31'd0, ovf_tr[6]}, 32'd1);

    // Reset mid-DATA with two bytes queued
    seq[0] = 8'h55; seq[1] = 8'h01; seq[2] = 8'h02;
    run(3, 10, -1);
    chk("t5 mid bit1 low", {31'd0, tx_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 async tx high", {31'd0, tx_o}, 32'd1);
    chk("t5 async busy low", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 60, -1);
    bad = 0;
    for (int k = 0; k <= 60; k++) if (tx_tr[k] !== 1'b1 || busy_tr[k] !== 1'b0) bad++;
    chk("t5 quiet after reset", bad, 0);

`ifdef VPROC_UART_TX_PARITY_EN
    seq[0] = 8'h07;
    run(1, 50, -1);
    chk("t6 parity 07 first", {31'd0, tx_tr[38]}, 32'd1);
    chk("t6 parity 07 last", {31'd0, tx_tr[41]}, 32'd1);
    chk("t6 stop after parity", {31'd0, tx_tr[42]}, 32'd1);
    chk("t6 busy c45", {31'd0, busy_tr[45]}, 32'd1);
    chk("t6 busy falls c46", {31'd0, busy_tr[46]}, 32'd0);
    seq[0] = 8'h03;
    run(1, 50, -1);
    chk("t6 parity 03 first", {31'd0, tx_tr[38]}, 32'd0);
    chk("t6 parity 03 last", {31'd0, tx_tr[41]}, 32'd0);
`endif

    // Random traffic: alternating bursty and sparse phases
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        we   = (p % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 39) == 0);
        data = 8'($urandom);
        clr  = ($urandom_range(0, 49) == 0);
      end
    end
    @(negedge clk);
    we = 1'b0; clr = 1'b0;
    repeat (4*FL*(DEPTH + 1) + 4) @(negedge clk);
    chk("drained busy", {31'd0, busy_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
